// File: rtl/display_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module  : display_scan_controller
//  Purpose : Multiplexed 8-digit seven-segment scanner with per-digit guard
//            blanking and frame-synchronous double-buffered digit data.
//  Rev     : 1.0  initial release
// ============================================================================
module display_scan_controller #(
    parameter int PRESCALE_DIV = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        Enable,
    input  logic        LoadStrobe,
    input  logic [31:0] DigitData,
    input  logic [7:0]  BlankMask,
    output logic [2:0]  CodedOutput,
    output logic [6:0]  SegmentOutput,
    output logic        DisplayEnable,
    output logic        FrameDone
);

    localparam int c_PRE_W = $clog2(PRESCALE_DIV);
    localparam int c_GRD_W = $clog2(GUARD_CYCLES + 1);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(PRESCALE_DIV - 1);
    localparam logic [c_GRD_W-1:0] c_GRD_LAST = c_GRD_W'(GUARD_CYCLES - 1);
    localparam logic [6:0]         c_SEG_OFF  = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISPLAY = 2'd1,
        GUARD   = 2'd2
    } state_t;

    state_t               r_state;
    logic [2:0]           r_index;
    logic [c_PRE_W-1:0]   r_prescaler;
    logic [c_GRD_W-1:0]   r_guardCnt;
    logic [31:0]          r_stagingData;
    logic [7:0]           r_stagingMask;
    logic                 r_pending;
    logic [31:0]          r_shadowData;
    logic [7:0]           r_shadowMask;
    logic [2:0]           r_codedOutput;
    logic [6:0]           r_segmentOutput;
    logic                 r_displayEnable;
    logic                 r_frameDone;

    logic                 w_guardLast;
    logic                 w_wrap;
    logic                 w_loadFromInputs;
    logic                 w_loadFromStaging;
    logic [31:0]          w_nextShadowData;
    logic [7:0]           w_nextShadowMask;
    logic [2:0]           w_dispIndex;
    logic [3:0]           w_dispNibble;
    logic [6:0]           w_dispSeg;
    logic                 w_dispBlank;

    function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // The shadow seen by the first cycle of the next digit must already include
    // any transfer happening on the same edge, so decode from the next value.
    always_comb begin
        w_guardLast       = (r_state == GUARD) && (r_guardCnt == c_GRD_LAST);
        w_wrap            = Enable && w_guardLast && (r_index == 3'd7);
        w_loadFromInputs  = LoadStrobe && ((r_state == IDLE) || w_wrap);
        w_loadFromStaging = !w_loadFromInputs && w_wrap && r_pending;
        w_nextShadowData  = r_shadowData;
        w_nextShadowMask  = r_shadowMask;
        if (w_loadFromInputs) begin
            w_nextShadowData = DigitData;
            w_nextShadowMask = BlankMask;
        end else if (w_loadFromStaging) begin
            w_nextShadowData = r_stagingData;
            w_nextShadowMask = r_stagingMask;
        end
        w_dispIndex  = (r_state == GUARD) ? (r_index + 3'd1) : 3'd0;
        w_dispNibble = w_nextShadowData[{w_dispIndex, 2'b00} +: 4];
        w_dispBlank  = w_nextShadowMask[w_dispIndex];
        w_dispSeg    = w_dispBlank ? c_SEG_OFF : hexToSeg(w_dispNibble);
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state         <= IDLE;
            r_index         <= 3'd0;
            r_prescaler     <= '0;
            r_guardCnt      <= '0;
            r_stagingData   <= 32'd0;
            r_stagingMask   <= 8'd0;
            r_pending       <= 1'b0;
            r_shadowData    <= 32'd0;
            r_shadowMask    <= 8'd0;
            r_codedOutput   <= 3'd0;
            r_segmentOutput <= c_SEG_OFF;
            r_displayEnable <= 1'b0;
            r_frameDone     <= 1'b0;
        end else begin
            r_shadowData <= w_nextShadowData;
            r_shadowMask <= w_nextShadowMask;
            if (LoadStrobe) begin
                r_stagingData <= DigitData;
                r_stagingMask <= BlankMask;
            end
            if (w_loadFromInputs || w_loadFromStaging) begin
                r_pending <= 1'b0;
            end else if (LoadStrobe) begin
                r_pending <= 1'b1;
            end
            r_frameDone <= 1'b0;

            if (!Enable) begin
                r_state         <= IDLE;
                r_index         <= 3'd0;
                r_prescaler     <= '0;
                r_guardCnt      <= '0;
                r_codedOutput   <= 3'd0;
                r_segmentOutput <= c_SEG_OFF;
                r_displayEnable <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state         <= DISPLAY;
                        r_index         <= 3'd0;
                        r_prescaler     <= '0;
                        r_codedOutput   <= 3'd0;
                        r_segmentOutput <= w_dispSeg;
                        r_displayEnable <= !w_dispBlank;
                    end
                    DISPLAY: begin
                        if (r_prescaler == c_PRE_LAST) begin
                            r_state         <= GUARD;
                            r_prescaler     <= '0;
                            r_guardCnt      <= '0;
                            r_segmentOutput <= c_SEG_OFF;
                            r_displayEnable <= 1'b0;
                        end else begin
                            r_prescaler <= r_prescaler + c_PRE_W'(1);
                        end
                    end
                    GUARD: begin
                        if (w_guardLast) begin
                            r_state         <= DISPLAY;
                            r_guardCnt      <= '0;
                            r_index         <= w_dispIndex;
                            r_codedOutput   <= w_dispIndex;
                            r_segmentOutput <= w_dispSeg;
                            r_displayEnable <= !w_dispBlank;
                            r_frameDone     <= w_wrap;
                        end else begin
                            r_guardCnt <= r_guardCnt + c_GRD_W'(1);
                        end
                    end
                    default: begin
                        r_state         <= IDLE;
                        r_index         <= 3'd0;
                        r_prescaler     <= '0;
                        r_guardCnt      <= '0;
                        r_codedOutput   <= 3'd0;
                        r_segmentOutput <= c_SEG_OFF;
                        r_displayEnable <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign CodedOutput   = r_codedOutput;
    assign SegmentOutput = r_segmentOutput;
    assign DisplayEnable = r_displayEnable;
    assign FrameDone     = r_frameDone;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module  : tb_display_scan_controller
//  Purpose : Directed bench for display_scan_controller (PRESCALE_DIV=4,
//            GUARD_CYCLES=2, 48-cycle frame).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_display_scan_controller;

    logic        Clk = 1'b0;
    logic        nReset;
    logic        Enable;
    logic        LoadStrobe;
    logic [31:0] DigitData;
    logic [7:0]  BlankMask;
    logic [2:0]  CodedOutput;
    logic [6:0]  SegmentOutput;
    logic        DisplayEnable;
    logic        FrameDone;

    int nCompared   = 0;
    int nMismatched = 0;
    int pos         = 0;

    display_scan_controller #(.PRESCALE_DIV(4), .GUARD_CYCLES(2)) dut (
        .Clk           (Clk),
        .nReset        (nReset),
        .Enable        (Enable),
        .LoadStrobe    (LoadStrobe),
        .DigitData     (DigitData),
        .BlankMask     (BlankMask),
        .CodedOutput   (CodedOutput),
        .SegmentOutput (SegmentOutput),
        .DisplayEnable (DisplayEnable),
        .FrameDone     (FrameDone)
    );

    always #5 Clk = ~Clk;

    function automatic logic [6:0] segOf(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Frame slot t: digit t/6, cycles 0..3 of the slot lit, 4..5 guard.
    function automatic logic expDe(input int t, input logic [7:0] m);
        return ((t % 6) < 4) && !m[t / 6];
    endfunction

    function automatic logic [6:0] expSeg(input int t, input logic [31:0] d, input logic [7:0] m);
        if (expDe(t, m)) return segOf(d[(t / 6) * 4 +: 4]);
        return 7'b1111111;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
        pos = (pos + 1) % 48;
    endtask

    task automatic advanceTo(input int target);
        while (pos != target) step();
    endtask

    task automatic test_reset();
        nReset = 1'b0; Enable = 1'b0; LoadStrobe = 1'b0;
        DigitData = 32'd0; BlankMask = 8'd0;
        #12;
        nCompared += 4;
        if (CodedOutput !== 3'd0) begin nMismatched++; $display("FAIL reset_code got %0d want 0", CodedOutput); end
        if (SegmentOutput !== 7'h7F) begin nMismatched++; $display("FAIL reset_seg got %b want 1111111", SegmentOutput); end
        if (DisplayEnable !== 1'b0) begin nMismatched++; $display("FAIL reset_de got %b want 0", DisplayEnable); end
        if (FrameDone !== 1'b0) begin nMismatched++; $display("FAIL reset_fd got %b want 0", FrameDone); end
        nReset = 1'b1;
        step();
        nCompared += 2;
        if (SegmentOutput !== 7'h7F) begin nMismatched++; $display("FAIL idle_seg got %b want 1111111", SegmentOutput); end
        if (DisplayEnable !== 1'b0) begin nMismatched++; $display("FAIL idle_de got %b want 0", DisplayEnable); end
    endtask

    task automatic test_scan();
        DigitData = 32'h76543210; BlankMask = 8'd0; LoadStrobe = 1'b1;
        step();
        LoadStrobe = 1'b0; DigitData = 32'd0;
        nCompared++;
        if (DisplayEnable !== 1'b0) begin nMismatched++; $display("FAIL idle_load_de got %b want 0", DisplayEnable); end
        Enable = 1'b1;
        step();
        pos = 0;
        for (int t = 0; t < 48; t++) begin
            if (t > 0) step();
            nCompared += 4;
            if (CodedOutput !== 3'(t / 6)) begin nMismatched++; $display("FAIL scan_code t=%0d got %0d want %0d", t, CodedOutput, t / 6); end
            if (SegmentOutput !== expSeg(t, 32'h76543210, 8'd0)) begin nMismatched++; $display("FAIL scan_seg t=%0d got %b want %b", t, SegmentOutput, expSeg(t, 32'h76543210, 8'd0)); end
            if (DisplayEnable !== expDe(t, 8'd0)) begin nMismatched++; $display("FAIL scan_de t=%0d got %b want %b", t, DisplayEnable, expDe(t, 8'd0)); end
            if (FrameDone !== 1'b0) begin nMismatched++; $display("FAIL scan_fd t=%0d got %b want 0", t, FrameDone); end
        end
    endtask

    task automatic test_frame_wrap();
        step();
        nCompared += 3;
        if (CodedOutput !== 3'd0) begin nMismatched++; $display("FAIL wrap_code got %0d want 0", CodedOutput); end
        if (FrameDone !== 1'b1) begin nMismatched++; $display("FAIL wrap_fd got %b want 1", FrameDone); end
        if (SegmentOutput !== 7'b1000000) begin nMismatched++; $display("FAIL wrap_seg got %b want 1000000", SegmentOutput); end
        step();
        nCompared++;
        if (FrameDone !== 1'b0) begin nMismatched++; $display("FAIL wrap_fd_pulse got %b want 0", FrameDone); end
    endtask

    task automatic test_midframe_load();
        logic [31:0] d;
        advanceTo(18);
        DigitData = 32'hFFFFFFFF; LoadStrobe = 1'b1;
        step();
        LoadStrobe = 1'b0; DigitData = 32'd0;
        for (int t = 19; t < 48 + 48; t++) begin
            if (t > 19) step();
            d = (t < 48) ? 32'h76543210 : 32'hFFFFFFFF;
            nCompared += 3;
            if (CodedOutput !== 3'((t % 48) / 6)) begin nMismatched++; $display("FAIL mid_code t=%0d got %0d want %0d", t, CodedOutput, (t % 48) / 6); end
            if (SegmentOutput !== expSeg(t % 48, d, 8'd0)) begin nMismatched++; $display("FAIL mid_seg t=%0d got %b want %b", t, SegmentOutput, expSeg(t % 48, d, 8'd0)); end
            if (FrameDone !== (t == 48)) begin nMismatched++; $display("FAIL mid_fd t=%0d got %b want %b", t, FrameDone, t == 48); end
        end
    endtask

    task automatic test_wrap_load_blank();
        DigitData = 32'h76543210; BlankMask = 8'b00000100; LoadStrobe = 1'b1;
        step();
        LoadStrobe = 1'b0; DigitData = 32'd0; BlankMask = 8'd0;
        for (int t = 0; t < 48; t++) begin
            if (t > 0) step();
            nCompared += 4;
            if (CodedOutput !== 3'(t / 6)) begin nMismatched++; $display("FAIL blank_code t=%0d got %0d want %0d", t, CodedOutput, t / 6); end
            if (SegmentOutput !== expSeg(t, 32'h76543210, 8'h04)) begin nMismatched++; $display("FAIL blank_seg t=%0d got %b want %b", t, SegmentOutput, expSeg(t, 32'h76543210, 8'h04)); end
            if (DisplayEnable !== expDe(t, 8'h04)) begin nMismatched++; $display("FAIL blank_de t=%0d got %b want %b", t, DisplayEnable, expDe(t, 8'h04)); end
            if (FrameDone !== (t == 0)) begin nMismatched++; $display("FAIL blank_fd t=%0d got %b want %b", t, FrameDone, t == 0); end
        end
    endtask

    task automatic test_enable_drop();
        advanceTo(31);
        Enable = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            nCompared += 4;
            if (CodedOutput !== 3'd0) begin nMismatched++; $display("FAIL drop_code k=%0d got %0d want 0", k, CodedOutput); end
            if (SegmentOutput !== 7'h7F) begin nMismatched++; $display("FAIL drop_seg k=%0d got %b want 1111111", k, SegmentOutput); end
            if (DisplayEnable !== 1'b0) begin nMismatched++; $display("FAIL drop_de k=%0d got %b want 0", k, DisplayEnable); end
            if (FrameDone !== 1'b0) begin nMismatched++; $display("FAIL drop_fd k=%0d got %b want 0", k, FrameDone); end
        end
        Enable = 1'b1;
        step();
        pos = 0;
        for (int t = 0; t < 12; t++) begin
            if (t > 0) step();
            nCompared += 4;
            if (CodedOutput !== 3'(t / 6)) begin nMismatched++; $display("FAIL restart_code t=%0d got %0d want %0d", t, CodedOutput, t / 6); end
            if (SegmentOutput !== expSeg(t, 32'h76543210, 8'h04)) begin nMismatched++; $display("FAIL restart_seg t=%0d got %b want %b", t, SegmentOutput, expSeg(t, 32'h76543210, 8'h04)); end
            if (DisplayEnable !== expDe(t, 8'h04)) begin nMismatched++; $display("FAIL restart_de t=%0d got %b want %b", t, DisplayEnable, expDe(t, 8'h04)); end
            if (FrameDone !== 1'b0) begin nMismatched++; $display("FAIL restart_fd t=%0d got %b want 0", t, FrameDone); end
        end
    endtask

    task automatic test_async_reset();
        advanceTo(10);
        nCompared++;
        if (CodedOutput !== 3'd1) begin nMismatched++; $display("FAIL pre_reset_code got %0d want 1", CodedOutput); end
        #2 nReset = 1'b0;
        #1;
        nCompared += 3;
        if (CodedOutput !== 3'd0) begin nMismatched++; $display("FAIL async_code got %0d want 0", CodedOutput); end
        if (SegmentOutput !== 7'h7F) begin nMismatched++; $display("FAIL async_seg got %b want 1111111", SegmentOutput); end
        if (DisplayEnable !== 1'b0) begin nMismatched++; $display("FAIL async_de got %b want 0", DisplayEnable); end
        #2 nReset = 1'b1;
        step();
        pos = 0;
        nCompared += 3;
        if (CodedOutput !== 3'd0) begin nMismatched++; $display("FAIL post_reset_code got %0d want 0", CodedOutput); end
        if (SegmentOutput !== 7'b1000000) begin nMismatched++; $display("FAIL post_reset_seg0 got %b want 1000000", SegmentOutput); end
        if (DisplayEnable !== 1'b1) begin nMismatched++; $display("FAIL post_reset_de got %b want 1", DisplayEnable); end
        advanceTo(6);
        nCompared += 2;
        if (CodedOutput !== 3'd1) begin nMismatched++; $display("FAIL post_reset_code1 got %0d want 1", CodedOutput); end
        if (SegmentOutput !== 7'b1000000) begin nMismatched++; $display("FAIL post_reset_seg1 got %b want 1000000", SegmentOutput); end
        advanceTo(12);
        nCompared++;
        if (DisplayEnable !== 1'b1) begin nMismatched++; $display("FAIL post_reset_de2 got %b want 1", DisplayEnable); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_frame_wrap();
        test_midframe_load();
        test_wrap_load_blank();
        test_enable_drop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
